pipe_hold_ctrl: RTL and testbench

// Central pipeline sequencer for the RV32 core. Sole driver of hold_flag to pc_reg, if_id and id_ex.

---
 rtl/pipe_hold_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_hold_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush sequencer: drives hold_flag to the pipe DFFs and owns the PC redirect.
// Optional stall-cycle counter enabled with `define PIPE_CTRL_PERF_EN.
module pipe_hold_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned BUS_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_req_i,
  input  logic [31:0] jump_addr_i,
  input  logic        mc_start_i,
  input  logic        mc_done_i,
  input  logic [31:0] mc_jump_addr_i,
  input  logic        irq_hold_i,
  input  logic        bus_hold_i,
  output logic [2:0]  hold_flag_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
`ifdef PIPE_CTRL_PERF_EN
  output logic        bus_err_o,
  output logic [31:0] stall_cnt_o
`else
  output logic        bus_err_o
`endif
);

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_ID   = 3'd3;

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_WAIT_MC, S_WAIT_BUS} state_e;

  localparam logic [2:0] FLUSH_LD  = 3'(FLUSH_CYCLES);
  // tcnt holds the number of held cycles already seen; the pulse fires on the
  // BUS_TIMEOUT-th consecutive cycle, counting the current one.
  localparam logic [7:0] TMO_LAST  = 8'(BUS_TIMEOUT - 1);
  localparam state_e     REDIR_NXT = (FLUSH_CYCLES > 0) ? S_FLUSH : S_IDLE;

  state_e      state_q, state_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [2:0]  hold;
  logic        jflag, berr, idle_eval;
  logic [31:0] jaddr;

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    tcnt_d    = tcnt_q;
    hold      = HOLD_NONE;
    jflag     = 1'b0;
    jaddr     = 32'd0;
    berr      = 1'b0;
    idle_eval = 1'b0;

    case (state_q)
      S_IDLE: idle_eval = 1'b1;
      S_FLUSH: begin
        hold = HOLD_ID;
        if (jump_req_i) begin
          jflag   = 1'b1;
          jaddr   = jump_addr_i;
          fcnt_d  = FLUSH_LD;
          state_d = REDIR_NXT;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
          if (fcnt_q <= 3'd1) state_d = S_IDLE;
        end
      end
      S_WAIT_MC: begin
        hold = HOLD_ID;
        if (mc_done_i) begin
          jflag   = 1'b1;
          jaddr   = mc_jump_addr_i;
          fcnt_d  = FLUSH_LD;
          state_d = REDIR_NXT;
        end
      end
      S_WAIT_BUS: begin
        if (!bus_hold_i || jump_req_i) begin
          idle_eval = 1'b1;
        end else begin
          hold = HOLD_PC;
          if (tcnt_q >= TMO_LAST) begin
            berr   = 1'b1;
            tcnt_d = 8'd0;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end
      end
      default: begin
        hold    = HOLD_ID;
        state_d = S_IDLE;
        fcnt_d  = 3'd0;
        tcnt_d  = 8'd0;
      end
    endcase

    // Shared IDLE arbitration, also used when leaving WAIT_BUS
    if (idle_eval) begin
      tcnt_d  = 8'd0;
      state_d = S_IDLE;
      if (jump_req_i) begin
        jflag   = 1'b1;
        jaddr   = jump_addr_i;
        hold    = HOLD_ID;
        fcnt_d  = FLUSH_LD;
        state_d = REDIR_NXT;
      end else if (mc_start_i) begin
        hold    = HOLD_ID;
        state_d = S_WAIT_MC;
      end else if (irq_hold_i) begin
        hold    = HOLD_ID;
      end else if (bus_hold_i) begin
        hold    = HOLD_PC;
        tcnt_d  = 8'd1;
        state_d = S_WAIT_BUS;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      fcnt_q  <= 3'd0;
      tcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Reset forces a full bubble immediately, independent of the clock
  assign hold_flag_o = rst ? hold : HOLD_ID;
  assign jump_flag_o = rst & jflag;
  assign jump_addr_o = (rst & jflag) ? jaddr : 32'd0;
  assign bus_err_o   = rst & berr;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_q <= 32'd0;
    else if (hold != HOLD_NONE && stall_q != 32'hFFFF_FFFF)
      stall_q <= stall_q + 32'd1;
  end
  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed bench for pipe_hold_ctrl (FLUSH_CYCLES=1, BUS_TIMEOUT=255).
module tb_pipe_hold_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        jump_req_i, mc_start_i, mc_done_i, irq_hold_i, bus_hold_i;
  logic [31:0] jump_addr_i, mc_jump_addr_i;
  logic [2:0]  hold_flag_o;
  logic        jump_flag_o, bus_err_o;
  logic [31:0] jump_addr_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  pipe_hold_ctrl #(.FLUSH_CYCLES(1), .BUS_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .jump_req_i(jump_req_i), .jump_addr_i(jump_addr_i),
    .mc_start_i(mc_start_i), .mc_done_i(mc_done_i), .mc_jump_addr_i(mc_jump_addr_i),
    .irq_hold_i(irq_hold_i), .bus_hold_i(bus_hold_i),
    .hold_flag_o(hold_flag_o), .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
`ifdef PIPE_CTRL_PERF_EN
    .bus_err_o(bus_err_o), .stall_cnt_o(stall_cnt_o)
`else
    .bus_err_o(bus_err_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Check outputs mid-cycle, then advance to just after the next rising edge.
  task automatic exp_cyc(input string tag, input logic [2:0] h, input logic jf,
                         input logic [31:0] ja, input logic be);
    @(negedge clk);
    chk({tag, ".hold"}, 32'(hold_flag_o), 32'(h));
    chk({tag, ".jflag"}, 32'(jump_flag_o), 32'(jf));
    chk({tag, ".jaddr"}, jump_addr_o, ja);
    chk({tag, ".berr"}, 32'(bus_err_o), 32'(be));
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    jump_req_i = 0; mc_start_i = 0; mc_done_i = 0; irq_hold_i = 0; bus_hold_i = 0;
    jump_addr_i = 32'h0; mc_jump_addr_i = 32'h0;
  endtask

  initial begin
    rst = 1'b0;
    idle_in();
    // reset state
    exp_cyc("rst", 3, 0, 0, 0);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) exp_cyc("t1_idle", 0, 0, 0, 0);

    // jump with one flush bubble
    jump_req_i = 1; jump_addr_i = 32'h100;
    exp_cyc("t2_c0", 3, 1, 32'h100, 0);
    idle_in();
    exp_cyc("t2_c1", 3, 0, 0, 0);
    exp_cyc("t2_c2", 0, 0, 0, 0);

    // multi-cycle op, stray jump ignored
    for (int c = 0; c <= 35; c++) begin
      mc_start_i = (c == 0); mc_done_i = (c == 33); jump_req_i = (c == 10);
      jump_addr_i = 32'hDEAD_0000; mc_jump_addr_i = 32'h84;
      exp_cyc("t3", (c <= 34) ? 3'd3 : 3'd0, c == 33, (c == 33) ? 32'h84 : 32'h0, 0);
    end
    idle_in();

    // bus timeout
    for (int c = 0; c <= 300; c++) begin
      bus_hold_i = (c < 300);
      exp_cyc("t4", (c < 300) ? 3'd1 : 3'd0, 0, 0, c == 254);
    end
    idle_in();

    // jump beats mc_start and irq; later mc_done ignored
    jump_req_i = 1; mc_start_i = 1; irq_hold_i = 1; jump_addr_i = 32'h200;
    exp_cyc("t5_c0", 3, 1, 32'h200, 0);
    jump_req_i = 0; mc_start_i = 0;
    exp_cyc("t5_c1", 3, 0, 0, 0);
    exp_cyc("t5_c2", 3, 0, 0, 0);
    irq_hold_i = 0;
    exp_cyc("t5_c3", 0, 0, 0, 0);
    exp_cyc("t5_c4", 0, 0, 0, 0);
    mc_done_i = 1; mc_jump_addr_i = 32'h999;
    exp_cyc("t5_c5", 0, 0, 0, 0);
    idle_in();
    exp_cyc("t5_c6", 0, 0, 0, 0);

    // jump during FLUSH reloads the flush
    jump_req_i = 1; jump_addr_i = 32'h300;
    exp_cyc("rl_c0", 3, 1, 32'h300, 0);
    jump_addr_i = 32'h304;
    exp_cyc("rl_c1", 3, 1, 32'h304, 0);
    idle_in();
    exp_cyc("rl_c2", 3, 0, 0, 0);
    exp_cyc("rl_c3", 0, 0, 0, 0);

    // jump while bus-held, bus hold re-entered after flush
    bus_hold_i = 1;
    exp_cyc("bj_c0", 1, 0, 0, 0);
    jump_req_i = 1; jump_addr_i = 32'h400;
    exp_cyc("bj_c1", 3, 1, 32'h400, 0);
    jump_req_i = 0;
    exp_cyc("bj_c2", 3, 0, 0, 0);
    exp_cyc("bj_c3", 1, 0, 0, 0);
    bus_hold_i = 0;
    exp_cyc("bj_c4", 0, 0, 0, 0);

    // async reset in the middle of WAIT_MC
    mc_start_i = 1;
    exp_cyc("t6_c0", 3, 0, 0, 0);
    mc_start_i = 0;
    exp_cyc("t6_c1", 3, 0, 0, 0);
    jump_req_i = 1; jump_addr_i = 32'h500;
    rst = 1'b0;
    #1;
    chk("t6_rst.hold", 32'(hold_flag_o), 32'd3);
    chk("t6_rst.jflag", 32'(jump_flag_o), 32'd0);
    chk("t6_rst.jaddr", jump_addr_o, 32'd0);
    @(posedge clk); #1;
    idle_in();
    rst = 1'b1;
`ifdef PIPE_CTRL_PERF_EN
    @(negedge clk);
    chk("t6_perf0", stall_cnt_o, 32'd0);
`endif
    exp_cyc("t6_rel", 0, 0, 0, 0);
    irq_hold_i = 1;
    exp_cyc("t6_irq0", 3, 0, 0, 0);
    exp_cyc("t6_irq1", 3, 0, 0, 0);
    irq_hold_i = 0;
`ifdef PIPE_CTRL_PERF_EN
    @(negedge clk);
    chk("t6_perf2", stall_cnt_o, 32'd2);
`endif
    exp_cyc("t6_end", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
